// File: rtl/alarm_led_sequencer.sv
// Animated alarm on the 16-LED bank: one-hot chase, then an all-on/all-off flash,
// repeating until acknowledged, the timer is reloaded, or the step budget runs out.
module alarm_led_sequencer #(
    parameter int unsigned TICK_DIV      = 25,
    parameter int unsigned FLASH_COUNT   = 4,
    parameter int unsigned TIMEOUT_STEPS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        zero_min,
    input  logic        zero_sec,
    input  logic        ack,
    output logic [15:0] led,
    output logic        alarm_active
);

    localparam int unsigned PRE_W  = 16;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned FL_W   = 5;

    localparam logic [PRE_W-1:0]  TICK_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(TIMEOUT_STEPS - 1);
    localparam logic [FL_W-1:0]   FLASH_LAST = FL_W'(2 * FLASH_COUNT - 1);
    localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(15);
    localparam logic [15:0]       LED_ALL    = 16'hFFFF;
    localparam logic [15:0]       LED_FIRST  = 16'h0001;

    typedef enum logic [2:0] {
        IDLE,
        CHASE,
        FLASH,
        HOLD,
        SILENT
    } state_t;

    state_t             state, state_nxt;
    logic [15:0]        led_nxt;
    logic               alarm_nxt;
    logic [PRE_W-1:0]   prescaler, pre_nxt;
    logic [STEP_W-1:0]  step_cnt, step_nxt;
    logic [POS_W-1:0]   pos, pos_nxt;
    logic [FL_W-1:0]    flash_cnt, flash_nxt;
    logic               exp_d;

    logic expired;
    logic trigger;
    logic tick;
    logic animating;

    assign expired   = zero_min & zero_sec;
    assign trigger   = expired & ~exp_d;
    assign tick      = (prescaler == TICK_LAST);
    assign animating = (state == CHASE) || (state == FLASH);

    // exp_d resets high so a 00:00 already present at reset does not fire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            led          <= '0;
            alarm_active <= 1'b0;
            prescaler    <= '0;
            step_cnt     <= '0;
            pos          <= '0;
            flash_cnt    <= '0;
            exp_d        <= 1'b1;
        end else begin
            state        <= state_nxt;
            led          <= led_nxt;
            alarm_active <= alarm_nxt;
            prescaler    <= pre_nxt;
            step_cnt     <= step_nxt;
            pos          <= pos_nxt;
            flash_cnt    <= flash_nxt;
            exp_d        <= expired;
        end
    end

    // Next state and pattern; priority: reload > ack > timeout > pattern advance
    always_comb begin
        state_nxt = state;
        led_nxt   = led;
        pre_nxt   = prescaler;
        step_nxt  = step_cnt;
        pos_nxt   = pos;
        flash_nxt = flash_cnt;

        if (animating) begin
            pre_nxt = tick ? '0 : prescaler + PRE_W'(1);
            if (tick && (step_cnt != '1)) begin
                step_nxt = step_cnt + STEP_W'(1);
            end
        end

        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = CHASE;
                    led_nxt   = LED_FIRST;
                    pos_nxt   = '0;
                    step_nxt  = '0;
                    pre_nxt   = '0;
                end
            end
            SILENT: begin
                if (!expired) begin
                    state_nxt = IDLE;
                    led_nxt   = '0;
                end
            end
            CHASE, FLASH, HOLD: begin
                if (!expired) begin
                    state_nxt = IDLE;
                    led_nxt   = '0;
                end else if (ack) begin
                    state_nxt = SILENT;
                    led_nxt   = '0;
                end else if (tick && animating) begin
                    if (step_cnt == STEP_LAST) begin
                        state_nxt = HOLD;
                        led_nxt   = LED_ALL;
                    end else if (state == CHASE) begin
                        if (pos == POS_LAST) begin
                            state_nxt = FLASH;
                            led_nxt   = LED_ALL;
                            flash_nxt = '0;
                        end else begin
                            pos_nxt = pos + POS_W'(1);
                            led_nxt = {led[14:0], 1'b0};
                        end
                    end else begin
                        if (flash_cnt == FLASH_LAST) begin
                            state_nxt = CHASE;
                            pos_nxt   = '0;
                            led_nxt   = LED_FIRST;
                        end else begin
                            flash_nxt = flash_cnt + FL_W'(1);
                            led_nxt   = ~led;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                led_nxt   = '0;
            end
        endcase

        alarm_nxt = (state_nxt == CHASE) || (state_nxt == FLASH) || (state_nxt == HOLD);
    end

endmodule
